// File: rtl/avalon_multi_timer_pkg.sv
// ---------------------------------------------------------------------------
// avalon_multi_timer_pkg : register map and bit indices shared by the timer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package avalon_multi_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_COMPARE  = 3'd3,
    REG_SNAP     = 3'd4,
    REG_PRESCALE = 3'd5
  } reg_off_e;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_PWM   = 4;
  localparam int CTL_W     = 5;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// ---------------------------------------------------------------------------
// timer_channel : one prescaled down-counter with timeout, snapshot and PWM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 8,
  parameter int PERIOD_RST = 49
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        irq,
  output logic        pwm
);

  logic [CNT_W-1:0] r_period, r_compare, r_counter, r_snapshot;
  logic [PRE_W-1:0] r_prescale, r_pre_cnt;
  logic [CTL_W-1:0] r_control;
  logic             r_run, r_to, r_delayed_zero, r_force_reload, r_pwm;

  logic w_wr_status, w_wr_ctl, w_wr_period, w_start, w_stop;
  logic w_tick, w_zero, w_timeout;
  logic w_unused;

  assign w_wr_status = wr_en && (reg_sel == REG_STATUS);
  assign w_wr_ctl    = wr_en && (reg_sel == REG_CONTROL);
  assign w_wr_period = wr_en && (reg_sel == REG_PERIOD);
  assign w_start     = w_wr_ctl && wdata[CTL_START];
  assign w_stop      = w_wr_ctl && wdata[CTL_STOP];

  assign w_tick    = r_run && (r_pre_cnt == r_prescale);
  assign w_zero    = (r_counter == '0);
  assign w_timeout = w_zero && !r_delayed_zero;

  // Upper writedata bits are dropped when fields are narrower than the bus.
  assign w_unused = ^wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period       <= CNT_W'(PERIOD_RST);
      r_counter      <= CNT_W'(PERIOD_RST);
      r_compare      <= '0;
      r_snapshot     <= '0;
      r_prescale     <= '0;
      r_pre_cnt      <= '0;
      r_control      <= '0;
      r_run          <= 1'b0;
      r_to           <= 1'b0;
      r_delayed_zero <= 1'b0;
      r_force_reload <= 1'b0;
      r_pwm          <= 1'b0;
    end else begin
      r_force_reload <= w_wr_period;
      r_delayed_zero <= w_zero;
      r_pwm          <= r_run && r_control[CTL_PWM] && (r_counter < r_compare);

      if (w_wr_period)                          r_period   <= wdata[CNT_W-1:0];
      if (wr_en && (reg_sel == REG_COMPARE))    r_compare  <= wdata[CNT_W-1:0];
      if (wr_en && (reg_sel == REG_PRESCALE))   r_prescale <= wdata[PRE_W-1:0];
      if (w_wr_ctl)                             r_control  <= wdata[CTL_W-1:0];
      if (wr_en && (reg_sel == REG_SNAP))       r_snapshot <= r_counter;

      if (!r_run || r_force_reload || w_tick) r_pre_cnt <= '0;
      else                                    r_pre_cnt <= r_pre_cnt + PRE_W'(1);

      // r_period already holds the value written the cycle before.
      if (r_force_reload)  r_counter <= r_period;
      else if (w_tick)     r_counter <= w_zero ? r_period : r_counter - CNT_W'(1);

      if (w_start)                                        r_run <= 1'b1;
      else if (w_stop || r_force_reload)                  r_run <= 1'b0;
      else if (w_tick && w_zero && !r_control[CTL_CONT])  r_run <= 1'b0;

      if (w_wr_status)     r_to <= 1'b0;
      else if (w_timeout)  r_to <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[ST_RUN] = r_run;
        rd_data[ST_TO]  = r_to;
      end
      REG_CONTROL:  rd_data = 32'(r_control);
      REG_PERIOD:   rd_data = 32'(r_period);
      REG_COMPARE:  rd_data = 32'(r_compare);
      REG_SNAP:     rd_data = 32'(r_snapshot);
      REG_PRESCALE: rd_data = 32'(r_prescale);
      default:      rd_data = '0;
    endcase
  end

  assign irq = r_to && r_control[CTL_ITO];
  assign pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/avalon_multi_timer.sv
// ---------------------------------------------------------------------------
// avalon_multi_timer : Avalon-MM slave wrapping NUM_CH independent timers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 8,
  parameter int PERIOD_RST = 49
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+2:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic [NUM_CH-1:0]          pwm_out
);

  localparam int ADDR_W = $clog2(NUM_CH) + 3;

  logic              w_wr;
  logic [ADDR_W-1:0] w_ch;
  logic [NUM_CH-1:0] w_wr_en;
  logic [31:0]       w_ch_rd [NUM_CH];
  logic [31:0]       w_rd_mux;

  assign w_wr = chipselect && !write_n;
  // Shift rather than slice so a single-channel build has a valid index.
  assign w_ch = address >> 3;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr_en[i] = w_wr && (w_ch == ADDR_W'(i));

    timer_channel #(
      .CNT_W      (CNT_W),
      .PRE_W      (PRE_W),
      .PERIOD_RST (PERIOD_RST)
    ) u_channel (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (w_wr_en[i]),
      .reg_sel (address[2:0]),
      .wdata   (writedata),
      .rd_data (w_ch_rd[i]),
      .irq     (irq_vec[i]),
      .pwm     (pwm_out[i])
    );
  end

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == ADDR_W'(i)) w_rd_mux = w_ch_rd[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd_mux;
  end

  assign irq = |irq_vec;

endmodule

`default_nettype wire
